// File: rtl/hrange_lanes_if.sv
// Bus between a parent and one hrange_lanes generator: command inputs
// (_start/base/limit/step), the beat stream (_valid/_ready/_out/_keep/_last)
// and the _done level.
interface hrange_lanes_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
);
  // Handshake: a beat on _out/_keep/_last transfers on a cycle where both
  // _valid and _ready are high. Once _valid rises, _valid and the beat stay
  // unchanged until that transfer cycle, unless _start or _reset abandons the
  // beat. _ready may change freely and never depends on _valid.
  logic                     _start;
  logic signed [WIDTH-1:0]  base;
  logic signed [WIDTH-1:0]  limit;
  logic signed [WIDTH-1:0]  step;
  logic                     _ready;
  logic                     _valid;
  logic [LANES*WIDTH-1:0]   _out;
  logic [LANES-1:0]         _keep;
  logic                     _last;
  logic                     _done;

  // Parent side.
  modport master (
    output _start, base, limit, step, _ready,
    input  _valid, _out, _keep, _last, _done
  );

  // Generator side.
  modport slave (
    input  _start, base, limit, step, _ready,
    output _valid, _out, _keep, _last, _done
  );
endinterface

// File: rtl/hrange_lanes.sv
// Lane-packed range(base, limit, step) generator. A cursor register holds the
// first value of the current beat; the beat itself (lane values, keep mask,
// last flag) is derived combinationally from registers only, so it is stable
// while the consumer stalls. All arithmetic is done in AW bits so that
// cursor + LANES*step can never wrap. State IDLE is encoded 0, RUN is 1.
module hrange_lanes #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic          _clock,
  input  logic          _reset,
  hrange_lanes_if.slave bus,
  output logic          dbg_state_o
);
  localparam int AW = WIDTH + $clog2(LANES) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    cur_q, cur_d;
  logic signed [WIDTH-1:0] lim_q, lim_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic signed [AW-1:0]    lim_x, step_x, nxt_cur;
  logic [LANES*WIDTH-1:0]  beat_out;
  logic [LANES-1:0]        beat_keep;
  logic                    beat_last;
  logic                    start_nonempty;

  function automatic logic signed [AW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{(AW-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // A value is in range when it has not yet reached limit in the direction
  // of step; a zero step puts nothing in range.
  function automatic logic in_range(input logic signed [AW-1:0] v,
                                    input logic signed [AW-1:0] lim,
                                    input logic signed [AW-1:0] stp);
    logic r;
    r = 1'b0;
    if (stp[AW-1]) r = (v > lim);
    else if (stp != '0) r = (v < lim);
    return r;
  endfunction

  assign lim_x  = sext(lim_q);
  assign step_x = sext(step_q);
  assign start_nonempty = in_range(sext(bus.base), sext(bus.limit), sext(bus.step));

  // Beat formation: walk the lanes from the cursor, zeroing lanes past limit.
  always_comb begin
    logic signed [AW-1:0] acc;
    acc       = cur_q;
    beat_out  = '0;
    beat_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_keep[k] = in_range(acc, lim_x, step_x);
      if (beat_keep[k]) beat_out[k*WIDTH +: WIDTH] = acc[WIDTH-1:0];
      acc = acc + step_x;
    end
    nxt_cur   = acc;
    beat_last = !beat_keep[LANES-1] || !in_range(acc, lim_x, step_x);
  end

  // Next state: _start always reloads; otherwise an accepted beat advances.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lim_d   = lim_q;
    step_d  = step_q;
    if (bus._start) begin
      lim_d   = bus.limit;
      step_d  = bus.step;
      cur_d   = sext(bus.base);
      state_d = start_nonempty ? S_RUN : S_IDLE;
    end else if (state_q == S_RUN && bus._ready) begin
      if (beat_last) state_d = S_IDLE;
      else cur_d = nxt_cur;
    end
  end

  // State and datapath registers; a same-cycle _start outranks _reset.
  always_ff @(posedge _clock) begin
    if (_reset && !bus._start) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      lim_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
    end
  end

  // Outputs: the beat is presented only in RUN, all zero otherwise.
  always_comb begin
    bus._valid  = (state_q == S_RUN);
    bus._done   = (state_q == S_IDLE);
    bus._out    = '0;
    bus._keep   = '0;
    bus._last   = 1'b0;
    dbg_state_o = state_q;
    if (state_q == S_RUN) begin
      bus._out  = beat_out;
      bus._keep = beat_keep;
      bus._last = beat_last;
    end
  end
endmodule

// File: tb/tb_hrange_lanes.sv
// Bench for hrange_lanes: four 8-bit instances with LANES = 2, 4, 1, 3.
// Expected beats come from a plain list-of-values model of range() chunked
// into beats; a monitor pops and compares each accepted beat and checks
// that stalled beats do not move.
module tb_hrange_lanes;
  localparam int W  = 8;
  localparam int NI = 4;
  localparam int EW = 37;  // {last, keep[3:0], out[31:0]}

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [NI-1:0]       d_start, d_reset, d_ready;
  logic signed [W-1:0] d_base [NI];
  logic signed [W-1:0] d_limit [NI];
  logic signed [W-1:0] d_step [NI];
  logic [NI-1:0]       m_valid, m_done, m_last, m_dbg;
  logic [31:0]         m_out [NI];
  logic [3:0]          m_keep [NI];
  int                  rdy_mode [NI] = '{default: 0};
  int                  checks = 0;
  int                  failures = 0;
  logic [EW-1:0]       exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
  logic                hold_v [NI];
  logic [EW-1:0]       hold_b [NI];

  hrange_lanes_if #(.WIDTH(W), .LANES(2)) if0 ();
  hrange_lanes_if #(.WIDTH(W), .LANES(4)) if1 ();
  hrange_lanes_if #(.WIDTH(W), .LANES(1)) if2 ();
  hrange_lanes_if #(.WIDTH(W), .LANES(3)) if3 ();

  hrange_lanes #(.WIDTH(W), .LANES(2)) dut0 (._clock(clk), ._reset(d_reset[0]), .bus(if0), .dbg_state_o(m_dbg[0]));
  hrange_lanes #(.WIDTH(W), .LANES(4)) dut1 (._clock(clk), ._reset(d_reset[1]), .bus(if1), .dbg_state_o(m_dbg[1]));
  hrange_lanes #(.WIDTH(W), .LANES(1)) dut2 (._clock(clk), ._reset(d_reset[2]), .bus(if2), .dbg_state_o(m_dbg[2]));
  hrange_lanes #(.WIDTH(W), .LANES(3)) dut3 (._clock(clk), ._reset(d_reset[3]), .bus(if3), .dbg_state_o(m_dbg[3]));

  assign if0._start = d_start[0];  assign if0.base = d_base[0];  assign if0.limit = d_limit[0];
  assign if0.step = d_step[0];     assign if0._ready = d_ready[0];
  assign m_valid[0] = if0._valid;  assign m_done[0] = if0._done;  assign m_last[0] = if0._last;
  assign m_out[0] = {16'b0, if0._out};  assign m_keep[0] = {2'b0, if0._keep};

  assign if1._start = d_start[1];  assign if1.base = d_base[1];  assign if1.limit = d_limit[1];
  assign if1.step = d_step[1];     assign if1._ready = d_ready[1];
  assign m_valid[1] = if1._valid;  assign m_done[1] = if1._done;  assign m_last[1] = if1._last;
  assign m_out[1] = if1._out;      assign m_keep[1] = if1._keep;

  assign if2._start = d_start[2];  assign if2.base = d_base[2];  assign if2.limit = d_limit[2];
  assign if2.step = d_step[2];     assign if2._ready = d_ready[2];
  assign m_valid[2] = if2._valid;  assign m_done[2] = if2._done;  assign m_last[2] = if2._last;
  assign m_out[2] = {24'b0, if2._out};  assign m_keep[2] = {3'b0, if2._keep};

  assign if3._start = d_start[3];  assign if3.base = d_base[3];  assign if3.limit = d_limit[3];
  assign if3.step = d_step[3];     assign if3._ready = d_ready[3];
  assign m_valid[3] = if3._valid;  assign m_done[3] = if3._done;  assign m_last[3] = if3._last;
  assign m_out[3] = {8'b0, if3._out};   assign m_keep[3] = {1'b0, if3._keep};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int lanes_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      2:       return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  task automatic q_push(input int i, input logic [EW-1:0] e);
    case (i)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      2:       exp_q2.push_back(e);
      default: exp_q3.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int i, output logic [EW-1:0] e);
    case (i)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      2:       e = exp_q2.pop_front();
      default: e = exp_q3.pop_front();
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      2:       exp_q2.delete();
      default: exp_q3.delete();
    endcase
  endtask

  // Reference: list the values of range(b, l, s) with integer arithmetic,
  // then cut the list into beats of L lanes; the final beat carries last.
  task automatic model_push(input int i, input int b, input int l, input int s);
    int            nl;
    int            vals[$];
    int            v;
    int            tmp;
    logic [31:0]   o;
    logic [3:0]    k;
    logic          last;
    nl = lanes_of(i);
    if (s != 0) begin
      v = b;
      while ((s > 0) ? (v < l) : (v > l)) begin
        vals.push_back(v);
        v = v + s;
      end
    end
    for (int bi = 0; bi * nl < vals.size(); bi++) begin
      o = '0;
      k = '0;
      for (int j = 0; j < nl; j++) begin
        if (bi * nl + j < vals.size()) begin
          tmp = vals[bi * nl + j];
          o[j*8 +: 8] = tmp[7:0];
          k[j] = 1'b1;
        end
      end
      last = ((bi + 1) * nl >= vals.size());
      q_push(i, {last, k, o});
    end
  endtask

  // Called at posedge+1; returns one cycle later, in the first cycle after
  // the start edge.
  task automatic start_seq(input int i, input int b, input int l, input int s, input bit with_rst);
    q_clear(i);
    model_push(i, b, l, s);
    d_base[i]  = b[7:0];
    d_limit[i] = l[7:0];
    d_step[i]  = s[7:0];
    d_start[i] = 1'b1;
    d_reset[i] = with_rst;
    @(posedge clk);
    #1;
    d_start[i] = 1'b0;
    d_reset[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string nm);
    int n;
    n = 0;
    while (!(q_size(i) == 0 && m_done[i]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_finished"}, 64'(n < 3000), 64'd1);
    chk({nm, "_idle_valid"}, 64'(m_valid[i]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int i, input int m);
    rdy_mode[i] = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 7));
    case (r)
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    d_ready = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        case (rdy_mode[i])
          0:       d_ready[i] = 1'b1;
          1:       d_ready[i] = 1'($urandom_range(0, 1));
          default: d_ready[i] = 1'b0;
        endcase
      end
    end
  end

  // Monitor: compare every accepted beat, and hold stalled beats steady.
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    for (int i = 0; i < NI; i++) begin
      hold_v[i] = 1'b0;
      hold_b[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        act = {m_last[i], m_keep[i], m_out[i]};
        if (hold_v[i]) begin
          chk($sformatf("stall_valid_dut%0d", i), 64'(m_valid[i]), 64'd1);
          chk($sformatf("stall_beat_dut%0d", i), 64'(act), 64'(hold_b[i]));
        end
        if (m_valid[i] && d_ready[i] && !d_start[i] && !d_reset[i]) begin
          if (q_size(i) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat_dut%0d: actual=%0h required=no beat", i, act);
          end else begin
            q_pop(i, e);
            chk($sformatf("beat_dut%0d", i), 64'(act), 64'(e));
          end
        end
        hold_v[i] = m_valid[i] && !d_ready[i] && !d_start[i] && !d_reset[i];
        hold_b[i] = act;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    d_start = '0;
    d_reset = '1;
    for (int i = 0; i < NI; i++) begin
      d_base[i]  = '0;
      d_limit[i] = '0;
      d_step[i]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_valid_dut%0d", i), 64'(m_valid[i]), 64'd0);
      chk($sformatf("reset_done_dut%0d", i), 64'(m_done[i]), 64'd1);
      chk($sformatf("reset_keep_dut%0d", i), 64'(m_keep[i]), 64'd0);
      chk($sformatf("reset_last_dut%0d", i), 64'(m_last[i]), 64'd0);
      chk($sformatf("reset_out_dut%0d", i), 64'(m_out[i]), 64'd0);
      chk($sformatf("reset_dbg_idle_dut%0d", i), 64'(m_dbg[i]), 64'd0);
    end
    @(posedge clk);
    #1;
    d_reset = '0;

    // (1,11,3), LANES=2: beats in cycles N+1, N+2; done in N+3.
    start_seq(0, 1, 11, 3, 0);
    @(negedge clk);
    chk("first_beat_valid", 64'(m_valid[0]), 64'd1);
    chk("first_beat_done", 64'(m_done[0]), 64'd0);
    @(negedge clk);
    chk("second_beat_valid", 64'(m_valid[0]), 64'd1);
    @(negedge clk);
    chk("done_after_last", 64'(m_done[0]), 64'd1);
    chk("valid_after_last", 64'(m_valid[0]), 64'd0);
    wait_done(0, "seq_1_11_3");

    start_seq(1, 0, 10, 2, 0);
    wait_done(1, "l4_0_10_2");
    start_seq(0, 10, 0, -3, 0);
    wait_done(0, "neg_step");

    // Empty sequences.
    start_seq(0, 5, 5, 1, 0);
    @(negedge clk);
    chk("empty_eq_valid", 64'(m_valid[0]), 64'd0);
    chk("empty_eq_done", 64'(m_done[0]), 64'd1);
    wait_done(0, "empty_eq");
    start_seq(0, 0, 10, 0, 0);
    @(negedge clk);
    chk("empty_zero_step_valid", 64'(m_valid[0]), 64'd0);
    chk("empty_zero_step_done", 64'(m_done[0]), 64'd1);
    wait_done(0, "empty_zero_step");

    // Near-overflow: no wrapped lane values.
    start_seq(0, 100, 127, 20, 0);
    wait_done(0, "ovf_l2");
    start_seq(2, 100, 127, 20, 0);
    wait_done(2, "ovf_l1");

    // Backpressure.
    set_mode(0, 1);
    start_seq(0, 0, 10, 1, 0);
    wait_done(0, "backpressure");
    set_mode(0, 0);

    // Reset after the first beat is accepted.
    start_seq(0, 0, 100, 1, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    q_clear(0);
    d_reset[0] = 1'b1;
    @(posedge clk);
    #1;
    d_reset[0] = 1'b0;
    @(negedge clk);
    chk("reset_mid_valid", 64'(m_valid[0]), 64'd0);
    chk("reset_mid_done", 64'(m_done[0]), 64'd1);
    @(posedge clk);
    #1;

    // _start together with _reset: start wins.
    start_seq(0, 3, 5, 1, 1);
    @(negedge clk);
    chk("start_over_reset_valid", 64'(m_valid[0]), 64'd1);
    wait_done(0, "start_over_reset");

    // Replace a stalled beat with a new sequence, no gap in _valid.
    set_mode(0, 2);
    start_seq(0, 0, 50, 1, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    start_seq(0, -20, -30, -4, 0);
    @(negedge clk);
    chk("replace_no_gap", 64'(m_valid[0]), 64'd1);
    set_mode(0, 0);
    wait_done(0, "replace");

    // Randomised sequences on every lane count, with occasional restarts.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 25; n++) begin
        rdy_mode[i] = int'($urandom_range(0, 1));
        start_seq(i, pick(), pick(), pick(), 0);
        if ($urandom_range(0, 4) == 0) begin
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #1;
          start_seq(i, pick(), pick(), pick(), 0);
        end
        wait_done(i, $sformatf("rand_dut%0d", i));
      end
      rdy_mode[i] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
